// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Two-entry elastic pipeline register (head + skid) sitting between two
// pipeline stages. The upstream ready is taken straight from a flop, so
// out_ready never reaches in_ready combinationally. The skid entry absorbs the
// one transfer that can arrive in the cycle the downstream stalls.
//
// Entries carry data, ctrl, err and halt. A control field of zero means the
// entry has no side effects; whenever the stage shows nothing valid, it
// presents ctrl = 0, halt = 0 and out_nop = 1 so downstream sees a bubble.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready is registered)
//   in_data/ctrl/err/halt  incoming entry fields
//   out_valid/out_ready  downstream handshake
//   out_data/ctrl/err/halt head entry fields; out_nop flags a bubble
//   flush                kill every held and incoming entry (branch taken)
//   occupancy            number of held entries, 0..2
//   stall_cnt            saturating count of cycles with out_valid & ~out_ready
//
// Build option
//   PIPE_STAGE_STATS_EN  when defined, stall_cnt is a live counter; otherwise
//                        it is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   // upstream
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_err,
   input  logic              in_halt,
   // downstream
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_err,
   output logic              out_halt,
   output logic              out_nop,
   // control / status
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [15:0]       stall_cnt
);

   // State encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_in_ready;
   logic              r_halted;

   logic [DATA_W-1:0] r_head_data;
   logic [CTRL_W-1:0] r_head_ctrl;
   logic              r_head_err;
   logic              r_head_halt;

   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic              r_skid_err;
   logic              r_skid_halt;

   logic              w_out_valid;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_halted_nxt;
   logic              w_full_nxt;

   assign w_out_valid = (r_state != EMPTY);
   assign w_in_xfer   = in_valid & r_in_ready;
   assign w_out_xfer  = w_out_valid & out_ready;

   // Once a halting entry has been accepted, no further entries may enter
   // until the pipeline is flushed or reset.
   assign w_halted_nxt = r_halted | (w_in_xfer & in_halt);

   // Buffer will be full after this edge: either it fills from ONE, or it
   // was already full and nothing left.
   assign w_full_nxt = ((r_state == ONE) & w_in_xfer & ~w_out_xfer) |
                       ((r_state == TWO) & ~w_out_xfer);

   // ---------------------------------------------------------------------------
   // Buffer FSM. Flush wins over any simultaneous in/out transfer; the entry
   // offered in the flush cycle is dropped, so a halt bit arriving then never
   // gets stored and never latches r_halted.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_halted    <= 1'b0;
         r_head_data <= '0;
         r_head_ctrl <= '0;
         r_head_err  <= 1'b0;
         r_head_halt <= 1'b0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_err  <= 1'b0;
         r_skid_halt <= 1'b0;
      end else if (flush) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_halted    <= 1'b0;
         r_head_data <= '0;
         r_head_ctrl <= '0;
         r_head_err  <= 1'b0;
         r_head_halt <= 1'b0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_err  <= 1'b0;
         r_skid_halt <= 1'b0;
      end else begin
         r_halted   <= w_halted_nxt;
         r_in_ready <= ~w_full_nxt & ~w_halted_nxt;

         unique case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  r_head_data <= in_data;
                  r_head_ctrl <= in_ctrl;
                  r_head_err  <= in_err;
                  r_head_halt <= in_halt;
                  r_state     <= ONE;
               end
            end

            ONE: begin
               if (w_in_xfer && !w_out_xfer) begin
                  // Downstream stalled: park the new entry behind the head.
                  r_skid_data <= in_data;
                  r_skid_ctrl <= in_ctrl;
                  r_skid_err  <= in_err;
                  r_skid_halt <= in_halt;
                  r_state     <= TWO;
               end else if (w_in_xfer && w_out_xfer) begin
                  // Pass-through: the head leaves and is replaced in place.
                  r_head_data <= in_data;
                  r_head_ctrl <= in_ctrl;
                  r_head_err  <= in_err;
                  r_head_halt <= in_halt;
               end else if (w_out_xfer) begin
                  r_state <= EMPTY;
               end
            end

            TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (w_out_xfer) begin
                  r_head_data <= r_skid_data;
                  r_head_ctrl <= r_skid_ctrl;
                  r_head_err  <= r_skid_err;
                  r_head_halt <= r_skid_halt;
                  r_state     <= ONE;
               end
            end

            default: begin
               r_state <= EMPTY;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: head entry, with the side-effect fields squashed into a bubble
   // whenever nothing valid is held.
   // ---------------------------------------------------------------------------
   assign in_ready  = r_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = r_head_data;
   assign out_ctrl  = w_out_valid ? r_head_ctrl : '0;
   assign out_err   = w_out_valid & r_head_err;
   assign out_halt  = w_out_valid & r_head_halt;
   assign out_nop   = ~w_out_valid;
   assign occupancy = r_state;

   // ---------------------------------------------------------------------------
   // Stall statistic. Survives flush on purpose: it measures backpressure over
   // the whole run, not per instruction stream.
   // ---------------------------------------------------------------------------
`ifdef PIPE_STAGE_STATS_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int DATA_W = 64;
   localparam int CTRL_W = 16;
`ifdef PIPE_STAGE_STATS_EN
   localparam logic [15:0] EXP_STALL = 16'd5;
`else
   localparam logic [15:0] EXP_STALL = 16'd0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              in_err;
   logic              in_halt;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              out_err;
   logic              out_halt;
   logic              out_nop;
   logic              flush;
   logic [1:0]        occupancy;
   logic [15:0]       stall_cnt;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] sb_q[$];

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_ctrl(in_ctrl), .in_err(in_err), .in_halt(in_halt),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ctrl(out_ctrl), .out_err(out_err), .out_halt(out_halt),
      .out_nop(out_nop), .flush(flush), .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score the handshakes that will fire at this edge, then advance
   // to 1 time unit past the edge so outputs can be sampled.
   task automatic cycle();
      logic [DATA_W-1:0] exp;
      if (flush) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL sb_underflow observed=%0h expected=none", out_data);
            end else begin
               exp = sb_q.pop_front();
               chk("pop_data", out_data, exp);
            end
         end
         if (in_valid && in_ready) sb_q.push_back(in_data);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; in_data = '0; in_ctrl = '0; in_err = 0;
      in_halt = 0; out_ready = 0; flush = 0;

      // ---- reset values
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_nop", out_nop, 1);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_halt", out_halt, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      #4 rst = 1'b0;
      @(posedge clk); #1;

      // ---- statistics: one entry held for 5 stalled cycles
      in_valid = 1; in_data = 64'h55; in_ctrl = 16'h1; out_ready = 0;
      cycle();
      in_valid = 0;
      chk("stat_latency_valid", out_valid, 1);
      chk("stat_latency_data", out_data, 64'h55);
      chk("stat_occ", occupancy, 1);
      repeat (5) cycle();
      chk("stat_stall_cnt", stall_cnt, EXP_STALL);
      chk("stat_data_stable", out_data, 64'h55);
      chk("stat_ctrl_stable", out_ctrl, 16'h1);
      out_ready = 1;
      cycle();
      chk("stat_drain_valid", out_valid, 0);
      chk("stat_drain_nop", out_nop, 1);

      // ---- streaming 1,2,3
      out_ready = 1;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1; in_data = 64'(i); in_ctrl = 16'(i);
         cycle();
         chk("stream_data", out_data, 64'(i));
         chk("stream_ctrl", out_ctrl, 64'(i));
         chk("stream_occ", occupancy, 1);
         chk("stream_in_ready", in_ready, 1);
      end
      in_valid = 0;
      cycle();
      chk("stream_drain_occ", occupancy, 0);

      // ---- backpressure A, B
      out_ready = 0;
      in_valid = 1; in_data = 64'hA; in_ctrl = 16'h2;
      cycle();
      in_data = 64'hB; in_ctrl = 16'h3;
      cycle();
      in_valid = 0;
      chk("bp_occ2", occupancy, 2);
      chk("bp_in_ready0", in_ready, 0);
      chk("bp_head_a", out_data, 64'hA);
      cycle();
      chk("bp_hold_a", out_data, 64'hA);
      out_ready = 1;
      cycle();
      chk("bp_then_b", out_data, 64'hB);
      chk("bp_occ1", occupancy, 1);
      chk("bp_in_ready1", in_ready, 1);
      cycle();
      chk("bp_drain_occ", occupancy, 0);

      // ---- flush while full, C offered in the flush cycle
      out_ready = 0;
      in_valid = 1; in_data = 64'hD; in_ctrl = 16'h4;
      cycle();
      in_data = 64'hE;
      cycle();
      chk("fl_occ2", occupancy, 2);
      in_data = 64'hC; flush = 1;
      #2;
      chk("fl_pre_edge_data", out_data, 64'hD);
      chk("fl_pre_edge_valid", out_valid, 1);
      cycle();
      flush = 0; in_valid = 0;
      chk("fl_occ0", occupancy, 0);
      chk("fl_nop", out_nop, 1);
      chk("fl_ctrl0", out_ctrl, 0);
      out_ready = 1;
      repeat (3) begin
         cycle();
         chk("fl_c_never_out", out_valid, 0);
      end

      // ---- flush + in + out together from ONE: flush wins
      in_valid = 1; in_data = 64'h11; in_ctrl = 16'h5;
      cycle();
      chk("fl3_occ1", occupancy, 1);
      in_data = 64'h22; flush = 1;
      cycle();
      flush = 0; in_valid = 0;
      chk("fl3_occ0", occupancy, 0);
      chk("fl3_valid0", out_valid, 0);

      // ---- halt
      out_ready = 1;
      in_valid = 1; in_data = 64'h77; in_ctrl = 16'h6; in_halt = 1;
      cycle();
      in_valid = 0; in_halt = 0;
      chk("halt_out_halt", out_halt, 1);
      chk("halt_in_ready0", in_ready, 0);
      cycle();
      chk("halt_popped_occ", occupancy, 0);
      chk("halt_out_halt0", out_halt, 0);
      chk("halt_still_blocked", in_ready, 0);
      cycle();
      chk("halt_still_blocked2", in_ready, 0);
      flush = 1;
      cycle();
      flush = 0;
      chk("halt_released", in_ready, 1);

      // ---- async reset between edges while full
      out_ready = 0;
      in_valid = 1; in_data = 64'h31; in_ctrl = 16'h7;
      cycle();
      in_data = 64'h32;
      cycle();
      in_valid = 0;
      chk("ar_occ2", occupancy, 2);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid0", out_valid, 0);
      chk("ar_occ0", occupancy, 0);
      chk("ar_in_ready1", in_ready, 1);
      chk("ar_stall0", stall_cnt, 0);
      sb_q.delete();
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // ---- clean transfer after reset
      out_ready = 1;
      in_valid = 1; in_data = 64'h99; in_ctrl = 16'h8;
      cycle();
      in_valid = 0;
      chk("post_rst_data", out_data, 64'h99);
      cycle();
      chk("post_rst_drain", occupancy, 0);
      chk("sb_empty_end", 64'(sb_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning payload width (operand data, immediate, PC).
REQ-002 SHALL have parameter CTRL_W, default 16, meaning control-field width; control field zero means no side effects.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATA_W, in_ctrl input CTRL_W, in_err input 1, in_halt input 1, meaning the upstream handshake and entry fields.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, out_data output DATA_W, out_ctrl output CTRL_W, out_err output 1, out_halt output 1, out_nop output 1, meaning the downstream handshake and head-entry fields.
REQ-007 SHALL have port flush, input, 1, meaning kill all held and incoming entries (branch taken).
REQ-008 SHALL have port occupancy, output, 2, meaning the number of held entries, 0..2.
REQ-009 SHALL have port stall_cnt, output, 16, meaning the stall statistic (see Configuration).

Function
REQ-010 SHALL hold a 2-entry buffer (head, skid); each entry stores data, ctrl, err, halt.
REQ-011 SHALL implement states EMPTY, ONE, TWO; occupancy = 0/1/2 respectively.
REQ-012 SHALL transfer in when in_valid & in_ready; SHALL transfer out when out_valid & out_ready.
REQ-013 SHALL drive in_ready from a register: 1 in EMPTY/ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-014 SHALL transition: EMPTY+in -> ONE; ONE+in-out -> TWO; ONE+out-in -> EMPTY; ONE+in+out -> ONE (head replaced); TWO+out -> ONE (skid moves to head); otherwise the state holds.
REQ-015 SHALL show the head entry on out_*; out_valid = (state != EMPTY).
REQ-016 SHALL force out_ctrl = 0, out_halt = 0 and out_nop = 1 whenever out_valid = 0; otherwise out_nop = 0.
REQ-017 SHALL keep out_data/out_ctrl/out_err/out_halt stable while out_valid & ~out_ready.
REQ-018 SHALL give 1-cycle latency: an entry accepted at edge N appears at out_* after edge N when the buffer was EMPTY.
REQ-019 SHALL, on flush, go to EMPTY at the next edge; the in transfer in the flush cycle is discarded and out_* is unaffected until that edge.
REQ-020 SHALL, once an accepted entry has halt = 1, hold in_ready = 0 until flush or rst.
REQ-021 SHALL store halt as 0 for an entry accepted in the flush cycle.
REQ-022 SHALL, with simultaneous in, out and flush, give flush priority: the result is EMPTY.

Reset
REQ-023 SHALL, when rst is asserted, immediately set state EMPTY, in_ready 1, out_valid 0, out_nop 1, out_ctrl 0, out_err 0, out_halt 0, out_data 0, occupancy 0, stall_cnt 0.
REQ-024 SHALL make rst asserted mid-transfer discard all entries; no partial entry survives.

Configuration
REQ-025 SHALL, with macro PIPE_STAGE_STATS_EN defined, count stall cycles: stall_cnt increments by 1 on every cycle with out_valid & ~out_ready, saturates at 0xFFFF, and is not cleared by flush.
REQ-026 SHALL, without PIPE_STAGE_STATS_EN, tie stall_cnt to 0 and add no counter logic.

Verification
REQ-027 SHALL cover streaming: out_ready = 1, in_valid every cycle with data 1, 2, 3 -> out_data 1, 2, 3 on consecutive cycles, occupancy 1, in_ready 1 throughout.
REQ-028 SHALL cover backpressure: out_ready = 0, push A, B -> occupancy 2, in_ready 0, out_data = A held; then out_ready = 1 -> A, then B, and in_ready returns to 1 one cycle after the first pop.
REQ-029 SHALL cover flush: in TWO, assert flush with in_valid = 1 and data C -> next cycle occupancy 0, out_nop 1, out_ctrl 0; C is never output.
REQ-030 SHALL cover halt: push an entry with halt = 1 -> in_ready 0 afterwards despite pops; after flush, in_ready = 1.
REQ-031 SHALL cover async reset: assert rst between edges while in TWO -> out_valid 0 and occupancy 0 before the next edge.
REQ-032 SHALL cover statistics: with PIPE_STAGE_STATS_EN, 5 stalled cycles -> stall_cnt = 5; without the macro -> stall_cnt = 0.
